// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: data memory geometry, address slice and byte-mask helper
package mem_stage_pkg;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW = 8;
  localparam int DATA_W = 32;
  localparam int IDX_LO = 2;
  localparam int IDX_HI = IDX_LO + DMEM_AW - 1;
  function automatic logic [DATA_W-1:0] byte_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) byte_mask[8*i +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/data_mem.sv
// data_mem: byte-enabled synchronous RAM, registered read returns pre-write data
module data_mem
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DMEM_DEPTH];
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with byte-masked data memory, LL/SC link and MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [3:0]        mMask,
  input  logic [DATA_W-1:0] rtData,
  input  logic              atomic,
  input  logic              regDst_in,
  input  logic              regWrite_in,
  input  logic              memToReg_in,
  input  logic              jal_in,
  input  logic              jr_in,
  input  logic [DATA_W-1:0] aluRes_in,
  output logic              regDst_out,
  output logic              regWrite_out,
  output logic              memToReg_out,
  output logic              jal_out,
  output logic              jr_out,
  output logic [DATA_W-1:0] aluRes_out,
  output logic              scSuccess_out,
  output logic [DATA_W-1:0] memData
);
  logic [DMEM_AW-1:0] idx, link_addr_d, link_addr_q;
  logic [DATA_W-1:0] rdata, alu_d, alu_q, rmask_d, rmask_q;
  logic [4:0] ctl_d, ctl_q;
  logic ll, sc, hit, sc_ok, we, link_valid_d, link_valid_q, sc_d, sc_q;
  always_comb begin
    idx = aluRes_in[IDX_HI:IDX_LO];
    ll = memRead & atomic;
    sc = memWrite & atomic;
    hit = link_addr_q == idx;
    sc_ok = sc & link_valid_q & hit;
    we = rst & memWrite & (~atomic | sc_ok);
    link_valid_d = (ll & ~sc) ? 1'b1 : (sc | (memWrite & hit)) ? 1'b0 : link_valid_q;
    link_addr_d = (ll & ~sc) ? idx : link_addr_q;
    sc_d = sc_ok;
    rmask_d = memRead ? byte_mask(mMask) : '0;
    ctl_d = {regDst_in, regWrite_in, memToReg_in, jal_in, jr_in};
    alu_d = aluRes_in;
  end
  // Load data leaves the RAM register; the registered mask zeroes it on reset or when no load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_valid_q <= 1'b0;
      link_addr_q <= '0;
      sc_q <= 1'b0;
      rmask_q <= '0;
      ctl_q <= '0;
      alu_q <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q <= link_addr_d;
      sc_q <= sc_d;
      rmask_q <= rmask_d;
      ctl_q <= ctl_d;
      alu_q <= alu_d;
    end
  end
  data_mem u_mem (
    .clk  (clk),
    .we   (we),
    .be   (mMask),
    .addr (idx),
    .wdata(rtData),
    .rdata(rdata)
  );
  assign {regDst_out, regWrite_out, memToReg_out, jal_out, jr_out} = ctl_q;
  assign aluRes_out = alu_q;
  assign scSuccess_out = sc_q;
  assign memData = rdata & rmask_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of loads, masked stores, LL/SC, passthrough and async reset
module tb_mem_stage;
  logic clk = 0, rst = 1;
  logic memRead = 0, memWrite = 0, atomic = 0;
  logic [3:0] mMask = 0;
  logic [31:0] rtData = 0, aluRes_in = 0;
  logic regDst_in = 0, regWrite_in = 0, memToReg_in = 0, jal_in = 0, jr_in = 0;
  logic regDst_out, regWrite_out, memToReg_out, jal_out, jr_out, scSuccess_out;
  logic [31:0] aluRes_out, memData;
  int checks = 0, errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .mMask(mMask),
    .rtData(rtData), .atomic(atomic), .regDst_in(regDst_in), .regWrite_in(regWrite_in),
    .memToReg_in(memToReg_in), .jal_in(jal_in), .jr_in(jr_in), .aluRes_in(aluRes_in),
    .regDst_out(regDst_out), .regWrite_out(regWrite_out), .memToReg_out(memToReg_out),
    .jal_out(jal_out), .jr_out(jr_out), .aluRes_out(aluRes_out),
    .scSuccess_out(scSuccess_out), .memData(memData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic at, input logic [3:0] m,
                    input logic [31:0] a, input logic [31:0] d);
    memRead = rd; memWrite = wr; atomic = at; mMask = m; aluRes_in = a; rtData = d;
    step();
  endtask

  function automatic logic [4:0] ctl();
    return {regDst_out, regWrite_out, memToReg_out, jal_out, jr_out};
  endfunction

  initial begin
    memRead = 1; aluRes_in = 32'hFFFF_FFFF; regWrite_in = 1; jal_in = 1;
    #1 rst = 0;
    #1;
    check("reset_alu", aluRes_out, 0);
    check("reset_ctl", {27'd0, ctl()}, 0);
    step();
    check("reset_hold_alu", aluRes_out, 0);
    check("reset_hold_mem", memData, 0);
    check("reset_hold_sc", {31'd0, scSuccess_out}, 0);
    rst = 1; regWrite_in = 0; jal_in = 0;

    op(0, 1, 0, 4'hF, 32'h10, 32'hDEADBEEF);
    check("store_memdata", memData, 0);
    check("store_sc", {31'd0, scSuccess_out}, 0);
    op(1, 0, 0, 4'hF, 32'h10, 0);
    check("load_full", memData, 32'hDEADBEEF);
    op(0, 1, 0, 4'b0011, 32'h10, 32'h11223344);
    op(1, 0, 0, 4'hF, 32'h10, 0);
    check("partial_store", memData, 32'hDEAD3344);
    op(1, 0, 0, 4'b0101, 32'h10, 0);
    check("load_mask_0101", memData, 32'h00AD0044);
    op(1, 0, 0, 4'b1010, 32'h10, 0);
    check("load_mask_1010", memData, 32'hDE003300);
    op(1, 0, 0, 4'hF, 32'h413, 0);
    check("addr_wrap", memData, 32'hDEAD3344);
    op(0, 1, 0, 4'h0, 32'h10, 32'hFFFFFFFF);
    op(1, 0, 0, 4'hF, 32'h10, 0);
    check("mask0_store", memData, 32'hDEAD3344);
    op(1, 1, 0, 4'hF, 32'h10, 32'hA5A5A5A5);
    check("read_before_write", memData, 32'hDEAD3344);
    op(1, 0, 0, 4'hF, 32'h10, 0);
    check("rbw_written", memData, 32'hA5A5A5A5);

    op(0, 1, 0, 4'hF, 32'h20, 0);
    op(1, 0, 1, 4'hF, 32'h20, 0);
    check("ll_load", memData, 0);
    check("ll_sc_flag", {31'd0, scSuccess_out}, 0);
    op(0, 1, 1, 4'hF, 32'h20, 32'hCAFEF00D);
    check("sc_success", {31'd0, scSuccess_out}, 1);
    op(1, 0, 0, 4'hF, 32'h20, 0);
    check("sc_success_data", memData, 32'hCAFEF00D);
    check("sc_flag_clears", {31'd0, scSuccess_out}, 0);
    op(0, 1, 1, 4'hF, 32'h20, 32'h1);
    check("sc_link_consumed", {31'd0, scSuccess_out}, 0);

    op(1, 0, 1, 4'hF, 32'h20, 0);
    op(0, 1, 0, 4'hF, 32'h20, 32'h55);
    op(0, 1, 1, 4'hF, 32'h20, 32'h1);
    check("sc_fail_after_store", {31'd0, scSuccess_out}, 0);
    op(1, 0, 0, 4'hF, 32'h20, 0);
    check("sc_fail_data", memData, 32'h55);

    op(1, 0, 1, 4'hF, 32'h20, 0);
    op(0, 1, 0, 4'hF, 32'h24, 32'h66);
    op(0, 1, 1, 4'hF, 32'h20, 32'h77);
    check("sc_other_store_ok", {31'd0, scSuccess_out}, 1);
    op(1, 0, 0, 4'hF, 32'h20, 0);
    check("sc_other_store_data", memData, 32'h77);

    op(1, 0, 1, 4'hF, 32'h20, 0);
    op(0, 1, 1, 4'hF, 32'h24, 32'h88);
    check("sc_wrong_addr", {31'd0, scSuccess_out}, 0);
    op(0, 1, 1, 4'hF, 32'h20, 32'h88);
    check("sc_after_wrong_addr", {31'd0, scSuccess_out}, 0);

    op(1, 0, 1, 4'hF, 32'h20, 0);
    op(1, 1, 1, 4'hF, 32'h20, 32'h99);
    check("llsc_same_sc", {31'd0, scSuccess_out}, 1);
    check("llsc_same_data", memData, 32'h77);
    op(0, 1, 1, 4'hF, 32'h20, 32'hAA);
    check("llsc_link_cleared", {31'd0, scSuccess_out}, 0);
    op(1, 0, 0, 4'hF, 32'h20, 0);
    check("llsc_word", memData, 32'h99);

    memRead = 0; memWrite = 0; atomic = 0;
    regWrite_in = 1; jal_in = 1; aluRes_in = 32'h12345678;
    #3;
    check("pass_before_edge", aluRes_out, 32'h20);
    step();
    check("pass_alu", aluRes_out, 32'h12345678);
    check("pass_ctl", {27'd0, ctl()}, 5'b01010);
    regDst_in = 1; regWrite_in = 0; memToReg_in = 1; jal_in = 0; jr_in = 1;
    op(1, 1, 0, 4'h0, 32'h3C, 0);
    check("pass_ctl2", {27'd0, ctl()}, 5'b10101);
    check("pass_alu2", aluRes_out, 32'h3C);

    regDst_in = 0; memToReg_in = 0; jr_in = 0; regWrite_in = 1;
    op(1, 0, 1, 4'hF, 32'h20, 0);
    check("pre_reset_load", memData, 32'h99);
    #2 rst = 0;
    #1;
    check("async_mem", memData, 0);
    check("async_alu", aluRes_out, 0);
    check("async_ctl", {27'd0, ctl()}, 0);
    op(0, 1, 0, 4'hF, 32'h20, 32'h1234);
    #2 rst = 1;
    regWrite_in = 0;
    op(0, 1, 1, 4'hF, 32'h20, 32'hBAD);
    check("sc_after_reset", {31'd0, scSuccess_out}, 0);
    op(1, 0, 0, 4'hF, 32'h20, 0);
    check("reset_no_write", memData, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
